// File: rtl/regfile_wb_queue_pkg.sv
// Shared constants and types for the register-file writeback queue.
// The widths match the ones the register file itself uses.
package regfile_wb_queue_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Writes to $zero are architecturally void and never occupy a slot.
    function automatic logic is_real_dest(input logic valid, input logic [ADDR_W-1:0] idx);
        return valid && (idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Pipeline-facing bundle of the writeback queue: two writeback lanes,
// the register-file write port, the two bypass lookups and the occupancy count.
interface regfile_wb_queue_if #(
    parameter int DEPTH = 4
);
    import regfile_wb_queue_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              wb0_valid;
    logic [ADDR_W-1:0] wb0_reg;
    logic [DATA_W-1:0] wb0_data;
    logic              wb1_valid;
    logic [ADDR_W-1:0] wb1_reg;
    logic [DATA_W-1:0] wb1_data;
    logic              wb_ready;

    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              write_enable;

    logic [ADDR_W-1:0] read_reg1;
    logic [ADDR_W-1:0] read_reg2;
    logic              byp_hit1;
    logic [DATA_W-1:0] byp_data1;
    logic              byp_hit2;
    logic [DATA_W-1:0] byp_data2;

    logic [CNT_W-1:0]  count;

    modport master (
        output wb0_valid, wb0_reg, wb0_data, wb1_valid, wb1_reg, wb1_data,
        output read_reg1, read_reg2,
        input  wb_ready, write_reg, write_data, write_enable,
        input  byp_hit1, byp_data1, byp_hit2, byp_data2, count
    );

    modport slave (
        input  wb0_valid, wb0_reg, wb0_data, wb1_valid, wb1_reg, wb1_data,
        input  read_reg1, read_reg2,
        output wb_ready, write_reg, write_data, write_enable,
        output byp_hit1, byp_data1, byp_hit2, byp_data2, count
    );

endinterface

// File: rtl/regfile_wb_queue_match.sv
// Youngest-match search over the occupied queue entries for one bypass lookup.
// Entries are walked oldest to youngest from the head, so the last match wins.
module regfile_wb_match
    import regfile_wb_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wb_entry_t         i_entries [DEPTH],
    input  logic [PTR_W-1:0]  i_head,
    input  logic [CNT_W-1:0]  i_count,
    input  logic [ADDR_W-1:0] i_index,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_data
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop leaves a latch.
        o_hit  = 1'b0;
        o_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < i_count) && (i_index != REG_ZERO) &&
                (i_entries[PTR_W'(i_head + PTR_W'(k))].idx == i_index)) begin
                o_hit  = 1'b1;
                o_data = i_entries[PTR_W'(i_head + PTR_W'(k))].data;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Serialises up to two writebacks per cycle onto the register file's single
// write port in program order, with bypass lookups over pending entries.
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    regfile_wb_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_ready;
    logic             w_push0;
    logic             w_push1;
    logic             w_pop;
    logic [CNT_W-1:0] w_push_cnt;
    logic [PTR_W-1:0] w_slot1;
    wb_entry_t        w_head_entry;

    // Only the registered count is trusted; a pop in the same cycle is not credited.
    assign w_ready    = r_count <= CNT_W'(DEPTH - 2);
    assign w_push0    = w_ready && is_real_dest(bus.wb0_valid, bus.wb0_reg);
    assign w_push1    = w_ready && is_real_dest(bus.wb1_valid, bus.wb1_reg);
    assign w_pop      = r_count != '0;
    assign w_push_cnt = CNT_W'(w_push0) + CNT_W'(w_push1);
    assign w_slot1    = w_push0 ? PTR_W'(r_tail + PTR_W'(1)) : r_tail;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use <= so every update sees the pre-edge values of the others.
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_head <= PTR_W'(r_head + PTR_W'(1));
            end
            r_tail  <= PTR_W'(r_tail + PTR_W'(w_push_cnt));
            r_count <= r_count + w_push_cnt - CNT_W'(w_pop);
        end
    end

    // NOTE: storage has no reset; the count qualifies every read, so stale slots are never seen.
    always_ff @(posedge clk) begin
        if (w_push0) begin
            r_mem[r_tail] <= '{idx: bus.wb0_reg, data: bus.wb0_data};
        end
        if (w_push1) begin
            r_mem[w_slot1] <= '{idx: bus.wb1_reg, data: bus.wb1_data};
        end
    end

    assign w_head_entry     = r_mem[r_head];
    assign bus.wb_ready     = w_ready;
    assign bus.write_enable = w_pop;
    assign bus.write_reg    = w_pop ? w_head_entry.idx  : REG_ZERO;
    assign bus.write_data   = w_pop ? w_head_entry.data : '0;
    assign bus.count        = r_count;

    regfile_wb_match #(.DEPTH(DEPTH)) u_match1 (
        .i_entries (r_mem),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_index   (bus.read_reg1),
        .o_hit     (bus.byp_hit1),
        .o_data    (bus.byp_data1)
    );

    regfile_wb_match #(.DEPTH(DEPTH)) u_match2 (
        .i_entries (r_mem),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_index   (bus.read_reg2),
        .o_hit     (bus.byp_hit2),
        .o_data    (bus.byp_data2)
    );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Scoreboard bench for regfile_wb_queue: issued writebacks queue their expected
// write-port beats; a negedge monitor pops and compares whatever the port drives.
module tb_regfile_wb_queue;
    import regfile_wb_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;

    regfile_wb_queue_if #(.DEPTH(DEPTH)) bus ();

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int        checks = 0;
    int        errors = 0;
    wb_entry_t exp_q [$];
    wb_entry_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every beat on the write port must be the oldest expected entry.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wr_unexpected actual reg=%0d data=0x%0h required no write",
                         bus.write_reg, bus.write_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_port", {27'd0, bus.write_reg, bus.write_data}, {27'd0, mon_e.idx, mon_e.data});
            end
        end
    end

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            assert (bus.wb_ready || !(bus.wb0_valid || bus.wb1_valid))
            else $error("FAIL protocol actual=valid while not ready required=no valid");
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v0, input logic [ADDR_W-1:0] r0, input logic [DATA_W-1:0] d0,
                         input logic v1, input logic [ADDR_W-1:0] r1, input logic [DATA_W-1:0] d1);
        bus.wb0_valid = v0; bus.wb0_reg = r0; bus.wb0_data = d0;
        bus.wb1_valid = v1; bus.wb1_reg = r1; bus.wb1_data = d1;
        if (v0 && r0 != 5'd0) exp_q.push_back('{idx: r0, data: d0});
        if (v1 && r1 != 5'd0) exp_q.push_back('{idx: r1, data: d1});
        tick();
        bus.wb0_valid = 1'b0;
        bus.wb1_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || bus.count != '0) && n < 20) begin
            tick();
            n++;
        end
        check({name, "_count"}, 64'(bus.count), 64'd0);
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.wb0_valid = 1'b0; bus.wb0_reg = '0; bus.wb0_data = '0;
        bus.wb1_valid = 1'b0; bus.wb1_reg = '0; bus.wb1_data = '0;
        bus.read_reg1 = '0;   bus.read_reg2 = '0;
        #2;
        check("rst_we",     64'(bus.write_enable), 64'd0);
        check("rst_count",  64'(bus.count),        64'd0);
        check("rst_ready",  64'(bus.wb_ready),     64'd1);
        check("rst_wreg",   64'(bus.write_reg),    64'd0);
        check("rst_wdata",  64'(bus.write_data),   64'd0);
        check("rst_hit",    {62'd0, bus.byp_hit1, bus.byp_hit2}, 64'd0);
        tick();
        reset = 1'b0;
        tick();

        // 1: reset mid-drain with three entries pending
        issue(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
        issue(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        check("t1_count3", 64'(bus.count),    64'd3);
        check("t1_busy",   64'(bus.wb_ready), 64'd0);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("t1_we_drop", 64'(bus.write_enable), 64'd0);
        tick();
        reset = 1'b0;
        #1;
        check("t1_count0", 64'(bus.count),    64'd0);
        check("t1_ready",  64'(bus.wb_ready), 64'd1);

        // 2: single write, one-cycle latency
        issue(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        check("t2_we",    64'(bus.write_enable), 64'd1);
        check("t2_reg",   64'(bus.write_reg),    64'd8);
        check("t2_data",  64'(bus.write_data),   64'hDEADBEEF);
        tick();
        check("t2_we_off", 64'(bus.write_enable), 64'd0);

        // 3: same register on both lanes, lane 1 is youngest
        issue(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2);
        bus.read_reg1 = 5'd5;
        #1;
        check("t3_count", 64'(bus.count),     64'd2);
        check("t3_hit",   64'(bus.byp_hit1),  64'd1);
        check("t3_data",  64'(bus.byp_data1), 64'h2);
        check("t3_first", 64'(bus.write_data), 64'h1);
        tick();
        check("t3_second",  64'(bus.write_data), 64'h2);
        check("t3_data_b",  64'(bus.byp_data1),  64'h2);
        tick();
        check("t3_hit_off", 64'(bus.byp_hit1), 64'd0);

        // 4: $zero lane dropped
        issue(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd3, 32'h7);
        check("t4_count", 64'(bus.count), 64'd1);
        bus.read_reg1 = 5'd0;
        #1;
        check("t4_zero_miss", 64'(bus.byp_hit1), 64'd0);
        bus.read_reg1 = 5'd3;
        #1;
        check("t4_hit",  64'(bus.byp_hit1),  64'd1);
        check("t4_data", 64'(bus.byp_data1), 64'h7);
        wait_drain("t4_drain");

        // 5: back-pressure and pointer wrap
        bus.read_reg1 = 5'd0;
        issue(1'b1, 5'd10, 32'hA0, 1'b0, 5'd0, 32'h0);
        issue(1'b1, 5'd11, 32'hB1, 1'b1, 5'd12, 32'hC2);
        check("t5_count2", 64'(bus.count),    64'd2);
        check("t5_ready",  64'(bus.wb_ready), 64'd1);
        issue(1'b1, 5'd13, 32'hD3, 1'b1, 5'd14, 32'hE4);
        check("t5_count3", 64'(bus.count),    64'd3);
        check("t5_full",   64'(bus.wb_ready), 64'd0);
        tick();
        check("t5_count_dn", 64'(bus.count),    64'd2);
        check("t5_ready_up", 64'(bus.wb_ready), 64'd1);
        wait_drain("t5_drain");

        // 6: bypass on the head entry retires with the pop
        issue(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
        bus.read_reg2 = 5'd9;
        #1;
        check("t6_we",   64'(bus.write_enable), 64'd1);
        check("t6_hit",  64'(bus.byp_hit2),     64'd1);
        check("t6_data", 64'(bus.byp_data2),    64'h99);
        tick();
        check("t6_we_off",  64'(bus.write_enable), 64'd0);
        check("t6_hit_off", 64'(bus.byp_hit2),     64'd0);

        wait_drain("final_drain");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
